// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU controls and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BEQ,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_ctrl_unit_alu_dec.sv
// Combinational ALU-control decoder: maps the ALU-op class plus funct to alu_ctl
// and flags whether funct names a supported R-type operation.
module mc_alu_dec
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  aluop_t              aluop,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                funct_legal
);

  logic [ALUCTL_W-1:0] fn_ctl;

  always_comb begin
    fn_ctl      = ALUCTL_W'(ALU_ADD);
    funct_legal = 1'b1;
    case (funct)
      FUNCT_W'(FN_ADD): fn_ctl = ALUCTL_W'(ALU_ADD);
      FUNCT_W'(FN_SUB): fn_ctl = ALUCTL_W'(ALU_SUB);
      FUNCT_W'(FN_AND): fn_ctl = ALUCTL_W'(ALU_AND);
      FUNCT_W'(FN_OR):  fn_ctl = ALUCTL_W'(ALU_OR);
      FUNCT_W'(FN_SLT): fn_ctl = ALUCTL_W'(ALU_SLT);
      default:          funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctl = ALUCTL_W'(ALU_ADD);
    case (aluop)
      ALUOP_SUB:   alu_ctl = ALUCTL_W'(ALU_SUB);
      ALUOP_FUNCT: alu_ctl = fn_ctl;
      default:     alu_ctl = ALUCTL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS control FSM with memory wait handshake and illegal-op trap;
// outputs are combinational from state. PERF_CNT_EN adds a retired-instruction counter.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic [1:0]          pcsrc,
  output logic                irwrite,
  output logic                pc_en,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                memwrite,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_t              state, state_nxt;
  aluop_t              aluop;
  logic [ALUCTL_W-1:0] dec_ctl;
  logic                funct_legal;
  logic                use_alu, pcwrite, branch;

  mc_alu_dec #(.FUNCT_W(FUNCT_W), .ALUCTL_W(ALUCTL_W)) u_alu_dec (
    .aluop       (aluop),
    .funct       (funct),
    .alu_ctl     (dec_ctl),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aluop     = ALUOP_ADD;
    use_alu   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    mem_req   = 1'b0;
    iord      = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_REG;
    pcsrc     = PC_ALU;
    irwrite   = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        use_alu = 1'b1;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH;
        use_alu = 1'b1;
        if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) state_nxt = S_MEMADR;
        else if (op == OP_W'(OP_RTYPE) && funct_legal) state_nxt = S_EXEC;
        else if (op == OP_W'(OP_BEQ))  state_nxt = S_BEQ;
        else if (op == OP_W'(OP_ADDI)) state_nxt = S_ADDIEX;
        else if (op == OP_W'(OP_J))    state_nxt = S_JUMP;
        else                           state_nxt = S_TRAP;
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_IMM;
        use_alu   = 1'b1;
        state_nxt = (op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg  = 1'b1;
        regwrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXEC: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_FUNCT;
        use_alu   = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regdst    = 1'b1;
        regwrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        use_alu   = 1'b1;
        pcsrc     = PC_ALUOUT;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_IMM;
        use_alu   = 1'b1;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = PC_JUMP;
        pcwrite   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        illegal   = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    alu_ctl = use_alu ? dec_ctl : '0;
    pc_en   = pcwrite | (branch & zero);
    // Reset overrides combinationally so a pending write is killed in the reset cycle itself.
    if (rst) begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = '0;
      alu_ctl  = '0;
      pcsrc    = '0;
      irwrite  = 1'b0;
      pc_en    = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt;

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  (state == S_ADDIWB) || (state == S_JUMP) ||
                  ((state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (retire) cnt <= cnt + CNT_W'(1);
  end

  assign retired = rst ? '0 : cnt;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: per-cycle expected control words built from the
// instruction-level rules, driven by a directed table plus random instructions.
module tb_mc_ctrl_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          mem_req, iord, alusrca, irwrite, pc_en, regdst, memtoreg;
  logic          regwrite, memwrite, illegal;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    alu_ctl;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  mc_ctrl_unit #(.OP_W(6), .FUNCT_W(6), .ALUCTL_W(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
    .alu_ctl(alu_ctl), .pcsrc(pcsrc), .irwrite(irwrite), .pc_en(pc_en),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .memwrite(memwrite),
    .illegal(illegal), .retired(retired)
  );

  typedef struct packed {
    logic       mem_req, iord, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alu_ctl;
    logic [1:0] pcsrc;
    logic       irwrite, pc_en, regdst, memtoreg, regwrite, memwrite, illegal;
  } ctl_t;

  ctl_t act;
  assign act = {mem_req, iord, alusrca, alusrcb, alu_ctl, pcsrc,
                irwrite, pc_en, regdst, memtoreg, regwrite, memwrite, illegal};

  typedef struct {
    logic rdy;
    logic zr;
    ctl_t exp;
    bit   ret;
  } cyc_t;

  typedef struct {
    string      nm;
    logic [5:0] op, funct;
    logic       zr;
    int         wf, wm;
    int         e_ill, e_rw, e_pc, e_mw;
  } vec_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcount = 0;
  int   n_ill, n_rw, n_pc, n_mw;

  function automatic logic [CW-1:0] exp_ret();
`ifdef PERF_CNT_EN
    return CW'(mcount);
`else
    return '0;
`endif
  endfunction

  function automatic logic [2:0] fn_op(input logic [5:0] f, output bit ok);
    ok = 1'b1;
    case (f)
      6'd32:   return 3'b010;
      6'd34:   return 3'b110;
      6'd36:   return 3'b000;
      6'd37:   return 3'b001;
      6'd42:   return 3'b111;
      default: begin ok = 1'b0; return 3'b000; end
    endcase
  endfunction

  task automatic check_ctl(input string nm, input ctl_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s ctl act=%h exp=%h op=%0d funct=%0d", nm, act, e, op, funct);
    end
  endtask

  task automatic check_ret(input string nm, input logic [CW-1:0] e);
    checks++;
    if (retired !== e) begin
      errors++;
      $display("FAIL %s retired act=%0d exp=%0d", nm, retired, e);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, a, e);
    end
  endtask

  task automatic push(input logic rdy, input logic zr, input ctl_t e, input bit r);
    cyc_t c;
    c.rdy = rdy; c.zr = zr; c.exp = e; c.ret = r;
    q.push_back(c);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t fetch_word(input bit done);
    ctl_t e = '0;
    e.mem_req = 1'b1; e.alusrcb = 2'd1; e.alu_ctl = 3'b010;
    e.irwrite = done; e.pc_en = done;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction from the ISA-level rules.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic zr,
                       input int wf, input int wm);
    ctl_t e;
    bit ok;
    logic [2:0] fc;
    q.delete();
    for (int i = 0; i <= wf; i++) push(i == wf, rbit(), fetch_word(i == wf), 1'b0);
    e = '0; e.alusrcb = 2'd3; e.alu_ctl = 3'b010;
    push(rbit(), rbit(), e, 1'b0);
    fc = fn_op(f, ok);
    if (o == 6'd35 || o == 6'd43) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'd2; e.alu_ctl = 3'b010;
      push(rbit(), rbit(), e, 1'b0);
      for (int i = 0; i <= wm; i++) begin
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = (o == 6'd43);
        push(i == wm, rbit(), e, (o == 6'd43) && (i == wm));
      end
      if (o == 6'd35) begin
        e = '0; e.memtoreg = 1'b1; e.regwrite = 1'b1;
        push(rbit(), rbit(), e, 1'b1);
      end
    end else if (o == 6'd0 && ok) begin
      e = '0; e.alusrca = 1'b1; e.alu_ctl = fc;
      push(rbit(), rbit(), e, 1'b0);
      e = '0; e.regdst = 1'b1; e.regwrite = 1'b1;
      push(rbit(), rbit(), e, 1'b1);
    end else if (o == 6'd4) begin
      e = '0; e.alusrca = 1'b1; e.alu_ctl = 3'b110; e.pcsrc = 2'd1; e.pc_en = zr;
      push(rbit(), zr, e, 1'b1);
    end else if (o == 6'd8) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'd2; e.alu_ctl = 3'b010;
      push(rbit(), rbit(), e, 1'b0);
      e = '0; e.regwrite = 1'b1;
      push(rbit(), rbit(), e, 1'b1);
    end else if (o == 6'd2) begin
      e = '0; e.pcsrc = 2'd2; e.pc_en = 1'b1;
      push(rbit(), rbit(), e, 1'b1);
    end else begin
      e = '0; e.illegal = 1'b1;
      push(rbit(), rbit(), e, 1'b0);
    end
  endtask

  // Inputs change at posedge+1; outputs are compared at the following negedge.
  task automatic run_n(input int n, input string nm);
    for (int i = 0; i < n && i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      zero      = q[i].zr;
      @(negedge clk);
      check_ctl(nm, q[i].exp);
      check_ret(nm, exp_ret());
      n_ill += int'(illegal);
      n_rw  += int'(regwrite);
      n_pc  += int'(pc_en);
      n_mw  += int'(memwrite);
      if (q[i].ret) mcount = (mcount + 1) % (1 << CW);
      @(posedge clk);
      #1;
    end
  endtask

  vec_t tbl[9];

  initial begin
    logic [CW-1:0] wrap_exp;
    ctl_t e;
    bit ok;
    logic [2:0] dummy;

    tbl[0] = '{nm:"lw_wait",  op:6'd35, funct:6'd0,  zr:1'b0, wf:2, wm:2, e_ill:0, e_rw:1, e_pc:1, e_mw:0};
    tbl[1] = '{nm:"r_slt",    op:6'd0,  funct:6'd42, zr:1'b0, wf:0, wm:0, e_ill:0, e_rw:1, e_pc:1, e_mw:0};
    tbl[2] = '{nm:"beq_taken",op:6'd4,  funct:6'd0,  zr:1'b1, wf:0, wm:0, e_ill:0, e_rw:0, e_pc:2, e_mw:0};
    tbl[3] = '{nm:"beq_not",  op:6'd4,  funct:6'd0,  zr:1'b0, wf:1, wm:0, e_ill:0, e_rw:0, e_pc:1, e_mw:0};
    tbl[4] = '{nm:"trap_op63",op:6'd63, funct:6'd0,  zr:1'b0, wf:0, wm:0, e_ill:1, e_rw:0, e_pc:1, e_mw:0};
    tbl[5] = '{nm:"trap_fn7", op:6'd0,  funct:6'd7,  zr:1'b0, wf:0, wm:0, e_ill:1, e_rw:0, e_pc:1, e_mw:0};
    tbl[6] = '{nm:"addi",     op:6'd8,  funct:6'd0,  zr:1'b0, wf:0, wm:0, e_ill:0, e_rw:1, e_pc:1, e_mw:0};
    tbl[7] = '{nm:"sw_wait",  op:6'd43, funct:6'd0,  zr:1'b0, wf:1, wm:3, e_ill:0, e_rw:0, e_pc:1, e_mw:4};
    tbl[8] = '{nm:"jump",     op:6'd2,  funct:6'd0,  zr:1'b0, wf:0, wm:0, e_ill:0, e_rw:0, e_pc:2, e_mw:0};

    // Reset state: outputs forced low regardless of inputs.
    rst = 1'b1; op = 6'd35; funct = 6'd42; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_ctl("reset_outputs", '0);
    check_ret("reset_retired", '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcount = 0;

    foreach (tbl[k]) begin
      op = tbl[k].op; funct = tbl[k].funct;
      build(tbl[k].op, tbl[k].funct, tbl[k].zr, tbl[k].wf, tbl[k].wm);
      n_ill = 0; n_rw = 0; n_pc = 0; n_mw = 0;
      run_n(q.size(), tbl[k].nm);
      check_int({tbl[k].nm, "_illegal_cnt"},  n_ill, tbl[k].e_ill);
      check_int({tbl[k].nm, "_regwrite_cnt"}, n_rw,  tbl[k].e_rw);
      check_int({tbl[k].nm, "_pc_en_cnt"},    n_pc,  tbl[k].e_pc);
      check_int({tbl[k].nm, "_memwrite_cnt"}, n_mw,  tbl[k].e_mw);
    end

    // Random instruction stream with random memory latencies.
    for (int n = 0; n < 250; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      funct = 6'($urandom_range(0, 63));
      case (sel)
        0: op = 6'd35;
        1: op = 6'd43;
        2: begin
          op = 6'd0;
          case ($urandom_range(0, 4))
            0: funct = 6'd32;
            1: funct = 6'd34;
            2: funct = 6'd36;
            3: funct = 6'd37;
            default: funct = 6'd42;
          endcase
        end
        3: op = 6'd4;
        4: op = 6'd8;
        5: op = 6'd2;
        6: op = 6'($urandom_range(0, 63));
        default: op = 6'd0;
      endcase
      build(op, funct, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
      run_n(q.size(), "random");
    end

    // sw interrupted by reset while waiting on memory.
    op = 6'd43; funct = 6'd0;
    build(6'd43, 6'd0, 1'b0, 0, 6);
    run_n(5, "sw_pre_reset");
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_int("rst_mid_memwr_memwrite", int'(memwrite), 0);
    check_ctl("rst_mid_memwr_outputs", '0);
    check_ret("rst_mid_memwr_retired", '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcount = 0;
    @(negedge clk);
    check_ctl("after_rst_fetch", fetch_word(1'b0));
    check_ret("after_rst_retired", '0);
    @(posedge clk);
    #1;

    // 17 jumps against a 4-bit counter: wraps to 1.
    op = 6'd2;
    for (int n = 0; n < 17; n++) begin
      build(6'd2, 6'd0, 1'b0, 0, 0);
      run_n(q.size(), "jump_wrap");
    end
`ifdef PERF_CNT_EN
    wrap_exp = 4'd1;
`else
    wrap_exp = 4'd0;
`endif
    @(negedge clk);
    check_ret("retired_wrap", wrap_exp);
    e = fetch_word(1'b0);
    dummy = fn_op(6'd0, ok);
    if (mem_ready) e = fetch_word(1'b1);
    check_ctl("post_wrap_fetch", e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
